// File: rtl/traffic_pkg.sv
// Shared widths, limits and light/event bit positions for the traffic sensor hub.
package traffic_pkg;

  localparam int COUNT_W   = 3;
  localparam int COUNT_MAX = 7;

  localparam int M_L    = 3;
  localparam int M_R    = 2;
  localparam int M_Y    = 1;
  localparam int M_G    = 0;
  localparam int S_G    = 0;
  localparam int P_WALK = 0;

  // Bit positions inside the five-wide detector event vector
  localparam int EV_MAIN = 0;
  localparam int EV_LEFT = 1;
  localparam int EV_SEC  = 2;
  localparam int EV_PED  = 3;
  localparam int EV_EMER = 4;
  localparam int EV_N    = 5;

endpackage

// File: rtl/lane_counter.sv
// One vehicle lane: saturating queue count plus a discharge timer that releases
// one vehicle every DEPART_CYCLES cycles of green while the queue is non-empty.
module lane_counter
  import traffic_pkg::*;
#(
  parameter int DEPART_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arrive,
  input  logic               green,
  output logic [COUNT_W-1:0] count
);

  localparam int TMR_W = $clog2(DEPART_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEPART_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q;
  logic             active;
  logic             depart;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_W'(COUNT_MAX)) ? v : v + COUNT_W'(1);
  endfunction

  function automatic logic [COUNT_W-1:0] sat_dec(input logic [COUNT_W-1:0] v);
    return (v == '0) ? v : v - COUNT_W'(1);
  endfunction

  assign active = green && (count != '0);
  assign depart = active && (tmr_q == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
      count <= '0;
    end else begin
      // Timer restarts on any loss of green so each green gets a full interval
      if (!active || depart) tmr_q <= '0;
      else                   tmr_q <= tmr_q + TMR_W'(1);

      if (arrive && !depart)      count <= sat_inc(count);
      else if (depart && !arrive) count <= sat_dec(count);
    end
  end

endmodule

// File: rtl/traffic_queue_sensor.sv
// Sensor hub: per-approach queue estimates, pedestrian count and emergency hold.
// Define SENSOR_DEBOUNCE_EN to add a 2-flop synchronizer and debouncer per detector.
module traffic_queue_sensor
  import traffic_pkg::*;
#(
  parameter int DEPART_CYCLES   = 8,
  parameter int EMER_HOLD       = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               main_det,
  input  logic               left_det,
  input  logic               sec_det,
  input  logic               p_btn,
  input  logic               emer_det,
  input  logic [3:0]         m_LRYG,
  input  logic [2:0]         s_RYG,
  input  logic [2:0]         p,
  output logic [COUNT_W-1:0] main_num,
  output logic [COUNT_W-1:0] left_num,
  output logic [COUNT_W-1:0] sec_num,
  output logic [COUNT_W-1:0] p_num,
  output logic               s_emergency
);

  localparam int HOLD_W = $clog2(EMER_HOLD + 1);

  logic [EV_N-1:0]   raw;
  logic [EV_N-1:0]   ev;
  logic [HOLD_W-1:0] hold_q;
  logic              unused_ok;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_W'(COUNT_MAX)) ? v : v + COUNT_W'(1);
  endfunction

  assign raw = {emer_det, p_btn, sec_det, left_det, main_det};

`ifdef SENSOR_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [EV_N-1:0] sync_p0;
  logic [EV_N-1:0] sync_p1;
  logic [EV_N-1:0] deb_lvl;
  logic [DB_W-1:0] db_cnt [EV_N];

  // Event fires on the cycle the debounced level is about to rise
  always_comb begin
    ev = '0;
    for (int i = 0; i < EV_N; i++)
      ev[i] = sync_p1[i] && !deb_lvl[i] && (db_cnt[i] == DB_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb_lvl <= '0;
      for (int i = 0; i < EV_N; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < EV_N; i++) begin
        if (sync_p1[i] == deb_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]  <= '0;
          deb_lvl[i] <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign unused_ok = ^{m_LRYG[2:1], s_RYG[2:1], p[2:1]};
`else
  assign ev        = raw;
  assign unused_ok = ^{m_LRYG[2:1], s_RYG[2:1], p[2:1], 1'(DEBOUNCE_CYCLES)};
`endif

  lane_counter #(.DEPART_CYCLES(DEPART_CYCLES)) u_main (
    .clk    (clk),
    .rst    (rst),
    .arrive (ev[EV_MAIN]),
    .green  (m_LRYG[M_G]),
    .count  (main_num)
  );

  lane_counter #(.DEPART_CYCLES(DEPART_CYCLES)) u_left (
    .clk    (clk),
    .rst    (rst),
    .arrive (ev[EV_LEFT]),
    .green  (m_LRYG[M_L]),
    .count  (left_num)
  );

  lane_counter #(.DEPART_CYCLES(DEPART_CYCLES)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .arrive (ev[EV_SEC]),
    .green  (s_RYG[S_G]),
    .count  (sec_num)
  );

  // Walk clears the waiting count and swallows any presses made during it
  always_ff @(posedge clk) begin
    if (rst)             p_num <= '0;
    else if (p[P_WALK])  p_num <= '0;
    else if (ev[EV_PED]) p_num <= sat_inc(p_num);
  end

  always_ff @(posedge clk) begin
    if (rst)                hold_q <= '0;
    else if (ev[EV_EMER])   hold_q <= HOLD_W'(EMER_HOLD);
    else if (hold_q != '0)  hold_q <= hold_q - HOLD_W'(1);
  end

  assign s_emergency = (hold_q != '0);

endmodule
